ebi_write_capture: RTL and testbench

Synchronous front end for the MCU's multiplexed external bus interface (EBI) inside the display driver. It samples the asynchronous EBI strobes and address/data bus in the `clk_100m` domain, latches the address on each ALE pulse and the data on each WE pulse, and buffers complete write transactions in a small FIFO. Downstream tile/sprite/palette memory writers pull transactions through a valid/ready port. The block is write-only; EBI reads are not serviced.

---
 rtl/ebi_write_capture_if.sv | 35 +++
 rtl/ebi_write_capture.sv | 146 ++++++++++++++
 tb/tb_ebi_write_capture.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ebi_write_capture_if.sv
//------------------------------------------------------------------------------
// Module      : ebi_write_capture_if
// Description : EBI strobes/bus toward the capture block plus its write-out port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ebi_write_capture_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [15:0]       EBI_AD;
    logic              EBI_ALE;
    logic              EBI_CS;
    logic              EBI_WE;
    logic              EBI_RE;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Capture block side: EBI target, write-port source.
    modport slave (
        input  EBI_AD, EBI_ALE, EBI_CS, EBI_WE, EBI_RE, wr_ready,
        output wr_valid, wr_addr, wr_data
    );

    // MCU/consumer side.
    modport master (
        output EBI_AD, EBI_ALE, EBI_CS, EBI_WE, EBI_RE, wr_ready,
        input  wr_valid, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/ebi_write_capture.sv
//------------------------------------------------------------------------------
// Module      : ebi_write_capture
// Description : Synchronises the multiplexed EBI, captures write transactions
//               into a small FIFO. Optional macro EBI_AUTOINC_EN auto-increments
//               the address after every accepted write.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ebi_write_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic                          clk_100m,
    input  logic                          btn_rst,
    ebi_write_capture_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_overflow,
    output logic                          err_noaddr
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam int c_ALE = 0;
    localparam int c_CS  = 1;
    localparam int c_WE  = 2;
    localparam int c_RE  = 3;

    logic [15:0]               r_ad_s1;
    logic [15:0]               r_ad_s2;
    logic [3:0]                r_stb_s1;
    logic [3:0]                r_stb_s2;
    logic [2:0]                r_stb_s3;
    logic [ADDR_W-1:0]         r_addr_reg;
    logic                      r_addr_vld;
    logic                      r_err_overflow;
    logic                      r_err_noaddr;
    logic [ADDR_W+DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;

    logic w_cs_sel;
    logic w_ale_rise;
    logic w_we_rise;
    logic w_cs_rise;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_unused;

    // Strobes and bus share the same two-stage delay so AD lines up with its strobe.
    always_ff @(posedge clk_100m) begin
        if (btn_rst) begin
            r_ad_s1  <= '0;
            r_ad_s2  <= '0;
            r_stb_s1 <= '1;
            r_stb_s2 <= '1;
            r_stb_s3 <= '1;
        end else begin
            r_ad_s1  <= bus.EBI_AD;
            r_ad_s2  <= r_ad_s1;
            r_stb_s1 <= {bus.EBI_RE, bus.EBI_WE, bus.EBI_CS, bus.EBI_ALE};
            r_stb_s2 <= r_stb_s1;
            r_stb_s3 <= r_stb_s2[2:0];
        end
    end

    // Read strobe is synchronised only; reads are not serviced.
    assign w_unused   = ^{r_stb_s2[c_RE], r_ad_s2};

    assign w_cs_sel   = ~r_stb_s2[c_CS];
    assign w_ale_rise = r_stb_s2[c_ALE] & ~r_stb_s3[c_ALE] & w_cs_sel;
    assign w_we_rise  = r_stb_s2[c_WE]  & ~r_stb_s3[c_WE]  & w_cs_sel;
    assign w_cs_rise  = r_stb_s2[c_CS]  & ~r_stb_s3[c_CS];

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = w_valid & bus.wr_ready;
    assign w_push  = w_we_rise & r_addr_vld & (~w_full | w_pop);

    always_ff @(posedge clk_100m) begin
        if (btn_rst) begin
            r_addr_reg     <= '0;
            r_addr_vld     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_noaddr   <= 1'b0;
        end else begin
            if (w_cs_rise) begin
                r_addr_vld <= 1'b0;
            end else if (w_ale_rise) begin
                r_addr_reg <= r_ad_s2[ADDR_W-1:0];
                r_addr_vld <= 1'b1;
            end
`ifdef EBI_AUTOINC_EN
            else if (w_push) begin
                r_addr_reg <= r_addr_reg + ADDR_W'(1);
            end
`endif
            if (w_we_rise && !r_addr_vld) begin
                r_err_noaddr <= 1'b1;
            end
            if (w_we_rise && r_addr_vld && w_full && !w_pop) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero while empty.
    always_ff @(posedge clk_100m) begin
        if (btn_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_addr_reg, r_ad_s2[DATA_W-1:0]};
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.wr_valid = w_valid;
    assign bus.wr_addr  = r_mem[r_rd_ptr][ADDR_W+DATA_W-1:DATA_W];
    assign bus.wr_data  = r_mem[r_rd_ptr][DATA_W-1:0];
    assign fifo_count   = r_count;
    assign err_overflow = r_err_overflow;
    assign err_noaddr   = r_err_noaddr;

endmodule

`default_nettype wire

// File: tb/tb_ebi_write_capture.sv
//------------------------------------------------------------------------------
// Module      : tb_ebi_write_capture
// Description : Directed self-checking bench for ebi_write_capture.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ebi_write_capture;

    localparam int c_ALE = 0;
    localparam int c_WE  = 2;

    logic       clk_100m = 1'b0;
    logic       btn_rst  = 1'b1;
    logic [2:0] fifo_count;
    logic       err_overflow;
    logic       err_noaddr;
    int         n_checks = 0;
    int         n_fail   = 0;

    ebi_write_capture_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ebi_write_capture #(
        .FIFO_DEPTH (4),
        .ADDR_W     (16),
        .DATA_W     (16)
    ) dut (
        .clk_100m     (clk_100m),
        .btn_rst      (btn_rst),
        .bus          (bus),
        .fifo_count   (fifo_count),
        .err_overflow (err_overflow),
        .err_noaddr   (err_noaddr)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic do_reset();
        @(negedge clk_100m);
        btn_rst      = 1'b1;
        bus.EBI_ALE  = 1'b1;
        bus.EBI_WE   = 1'b1;
        bus.EBI_RE   = 1'b1;
        bus.EBI_CS   = 1'b1;
        bus.EBI_AD   = 16'h0;
        bus.wr_ready = 1'b0;
        idle(3);
        btn_rst = 1'b0;
        idle(2);
    endtask

    // Low for 4 clocks, returns on the negedge where the strobe rises; AD left stable.
    task automatic strobe(input int which, input logic [15:0] ad);
        @(negedge clk_100m);
        bus.EBI_AD = ad;
        if (which == c_ALE) bus.EBI_ALE = 1'b0;
        else                bus.EBI_WE  = 1'b0;
        idle(4);
        if (which == c_ALE) bus.EBI_ALE = 1'b1;
        else                bus.EBI_WE  = 1'b1;
    endtask

    task automatic ebi_write(input logic [15:0] a, input logic [15:0] d);
        strobe(c_ALE, a);
        idle(4);
        strobe(c_WE, d);
        idle(4);
    endtask

    task automatic select(input logic cs);
        @(negedge clk_100m);
        bus.EBI_CS = cs;
        idle(3);
    endtask

    initial begin
        logic [15:0] exp_a;

        do_reset();
        check("rst_valid", {31'b0, bus.wr_valid}, 32'd0);
        check("rst_addr",  {16'b0, bus.wr_addr},  32'd0);
        check("rst_data",  {16'b0, bus.wr_data},  32'd0);
        check("rst_count", {29'b0, fifo_count},   32'd0);
        check("rst_ovf",   {31'b0, err_overflow}, 32'd0);
        check("rst_noaddr",{31'b0, err_noaddr},   32'd0);

        // Basic write and push latency
        select(1'b0);
        strobe(c_ALE, 16'd5);
        idle(4);
        strobe(c_WE, 16'd50);
        @(posedge clk_100m);
        @(posedge clk_100m);
        #1 check("lat_k1_valid", {31'b0, bus.wr_valid}, 32'd0);
        @(posedge clk_100m);
        #1 check("lat_k2_valid", {31'b0, bus.wr_valid}, 32'd1);
        check("t1_addr", {16'b0, bus.wr_addr}, 32'd5);
        check("t1_data", {16'b0, bus.wr_data}, 32'd50);
        idle(4);
        check("t1_count", {29'b0, fifo_count}, 32'd1);

        // Second write held, then two pops
        ebi_write(16'd15, 16'd30);
        check("t2_count", {29'b0, fifo_count}, 32'd2);
        check("t2_head_addr", {16'b0, bus.wr_addr}, 32'd5);
        check("t2_head_data", {16'b0, bus.wr_data}, 32'd50);
        @(negedge clk_100m);
        bus.wr_ready = 1'b1;
        @(posedge clk_100m);
        #1 check("pop1_addr", {16'b0, bus.wr_addr}, 32'd15);
        check("pop1_data", {16'b0, bus.wr_data}, 32'd30);
        check("pop1_valid", {31'b0, bus.wr_valid}, 32'd1);
        @(posedge clk_100m);
        #1 check("pop2_valid", {31'b0, bus.wr_valid}, 32'd0);
        check("pop2_count", {29'b0, fifo_count}, 32'd0);
        @(negedge clk_100m);
        bus.wr_ready = 1'b0;

        // WE without address
        do_reset();
        select(1'b0);
        strobe(c_WE, 16'd9);
        idle(4);
        check("noaddr_count", {29'b0, fifo_count}, 32'd0);
        check("noaddr_flag",  {31'b0, err_noaddr}, 32'd1);
        check("noaddr_ovf",   {31'b0, err_overflow}, 32'd0);

        // Overflow: five writes into four entries
        do_reset();
        select(1'b0);
        for (int i = 0; i < 5; i++) ebi_write(16'(10 + i), 16'(100 + i));
        check("ovf_count", {29'b0, fifo_count}, 32'd4);
        check("ovf_flag",  {31'b0, err_overflow}, 32'd1);
        @(negedge clk_100m);
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_fifo_addr", {16'b0, bus.wr_addr}, 32'(10 + i));
            check("ovf_fifo_data", {16'b0, bus.wr_data}, 32'(100 + i));
            @(negedge clk_100m);
        end
        check("ovf_drain_valid", {31'b0, bus.wr_valid}, 32'd0);
        bus.wr_ready = 1'b0;

        // Full with simultaneous pop: fifth write accepted
        do_reset();
        select(1'b0);
        for (int i = 0; i < 4; i++) ebi_write(16'(10 + i), 16'(100 + i));
        strobe(c_ALE, 16'd14);
        idle(4);
        strobe(c_WE, 16'd104);
        @(negedge clk_100m);
        @(negedge clk_100m);
        bus.wr_ready = 1'b1;
        @(negedge clk_100m);
        bus.wr_ready = 1'b0;
        idle(2);
        check("full_pp_count", {29'b0, fifo_count}, 32'd4);
        check("full_pp_ovf",   {31'b0, err_overflow}, 32'd0);
        @(negedge clk_100m);
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_addr", {16'b0, bus.wr_addr}, 32'(11 + i));
            check("full_pp_data", {16'b0, bus.wr_data}, 32'(101 + i));
            @(negedge clk_100m);
        end
        bus.wr_ready = 1'b0;

        // Strobes while deselected are ignored
        do_reset();
        strobe(c_ALE, 16'd3);
        idle(4);
        strobe(c_WE, 16'd4);
        idle(4);
        check("cs1_count",  {29'b0, fifo_count}, 32'd0);
        check("cs1_noaddr", {31'b0, err_noaddr}, 32'd0);
        check("cs1_ovf",    {31'b0, err_overflow}, 32'd0);

        // Deselect discards the latched address
        select(1'b0);
        strobe(c_ALE, 16'd7);
        idle(4);
        select(1'b1);
        select(1'b0);
        strobe(c_WE, 16'd8);
        idle(4);
        check("desel_noaddr", {31'b0, err_noaddr}, 32'd1);
        check("desel_count",  {29'b0, fifo_count}, 32'd0);

        // One ALE, three WE pulses
        do_reset();
        select(1'b0);
        strobe(c_ALE, 16'h0100);
        idle(4);
        for (int i = 1; i <= 3; i++) begin
            strobe(c_WE, 16'(i));
            idle(4);
        end
        check("seq_count", {29'b0, fifo_count}, 32'd3);
        @(negedge clk_100m);
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
`ifdef EBI_AUTOINC_EN
            exp_a = 16'(16'h0100 + i);
`else
            exp_a = 16'h0100;
`endif
            check("seq_addr", {16'b0, bus.wr_addr}, {16'b0, exp_a});
            check("seq_data", {16'b0, bus.wr_data}, 32'(i + 1));
            @(negedge clk_100m);
        end
        bus.wr_ready = 1'b0;
        check("seq_empty", {31'b0, bus.wr_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
